// File: rtl/uart_rx_fifo_if.sv
// Byte stream handshake between the UART receiver FIFO and its consumer.
interface uart_rx_fifo_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;

    // Receiver side: presents the FIFO head and accepts pops.
    modport master (
        output rx_data,
        output rx_valid,
        input  rx_ready
    );

    // Consumer side.
    modport slave (
        input  rx_data,
        input  rx_valid,
        output rx_ready
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver feeding a first-word-fall-through byte FIFO.
// Framing errors and overruns are reported as registered one-cycle pulses.
module uart_rx_fifo #(
    parameter int unsigned CLOCK_FREQUENCY = 12000000,
    parameter int unsigned UART_BAUD_RATE  = 9600,
    parameter int unsigned FIFO_DEPTH      = 4
) (
    input  logic                                clock,
    input  logic                                reset_n,
    input  logic                                uart_rx,
    uart_rx_fifo_if.master                      rx_if,
    output logic                                rx_busy,
    output logic                                frame_error,
    output logic                                overrun,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]     fifo_count
);

    localparam int unsigned DIV    = CLOCK_FREQUENCY / UART_BAUD_RATE;
    localparam int unsigned BAUD_W = $clog2(DIV);
    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH + 1);

    localparam logic [BAUD_W-1:0] HALF_LAST = BAUD_W'(DIV / 2 - 1);
    localparam logic [BAUD_W-1:0] FULL_LAST = BAUD_W'(DIV - 1);

    typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StWaitIdle} state_e;

    state_e              state_q, state_d;
    logic [1:0]          sync_q;
    logic                rxs;
    logic [BAUD_W-1:0]   cnt_q, cnt_d;
    logic [2:0]          bit_idx_q, bit_idx_d;
    logic [7:0]          shift_q, shift_d;

    logic                push_req, ferr_event;
    logic                pop, push, full, drop;

    logic [7:0]          mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]    wptr_q, rptr_q;
    logic [CNT_W-1:0]    count_q, count_d;
    logic                frame_error_q, overrun_q;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign rxs = sync_q[1];

    // Two-flop synchronizer for the asynchronous serial line, idles high.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], uart_rx};
        end
    end

    // FSM state and receive datapath registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
        end
    end

    // Next-state logic: mid-bit sampling driven by the baud counter.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + BAUD_W'(1);
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (!rxs) state_d = StStart;
            end
            StStart: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d = '0;
                    if (!rxs) begin
                        state_d   = StData;
                        bit_idx_d = '0;
                    end else begin
                        // Line went back high before mid-start: a glitch.
                        state_d = StIdle;
                    end
                end
            end
            StData: begin
                if (cnt_q == FULL_LAST) begin
                    cnt_d            = '0;
                    shift_d[bit_idx_q] = rxs;
                    if (bit_idx_q == 3'd7) state_d = StStop;
                    else                   bit_idx_d = bit_idx_q + 3'd1;
                end
            end
            StStop: begin
                if (cnt_q == FULL_LAST) begin
                    cnt_d   = '0;
                    state_d = rxs ? StIdle : StWaitIdle;
                end
            end
            StWaitIdle: begin
                cnt_d = '0;
                if (rxs) state_d = StIdle;
            end
            default: begin
                cnt_d   = '0;
                state_d = StIdle;
            end
        endcase
    end

    // FSM outputs: busy flag and stop-bit sample strobes.
    always_comb begin
        rx_busy    = (state_q != StIdle);
        push_req   = (state_q == StStop) && (cnt_q == FULL_LAST) && rxs;
        ferr_event = (state_q == StStop) && (cnt_q == FULL_LAST) && !rxs;
    end

    // FIFO control: a pop in the same cycle frees room for a push into a full FIFO.
    always_comb begin
        pop   = rx_if.rx_valid && rx_if.rx_ready;
        full  = (count_q == CNT_W'(FIFO_DEPTH));
        push  = push_req && (!full || pop);
        drop  = push_req && full && !pop;
        count_d = count_q;
        if (push && !pop)      count_d = count_q + CNT_W'(1);
        else if (pop && !push) count_d = count_q - CNT_W'(1);
    end

    // FIFO storage, pointers and registered event pulses.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
            wptr_q        <= '0;
            rptr_q        <= '0;
            count_q       <= '0;
            frame_error_q <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            if (push) begin
                mem_q[wptr_q] <= shift_q;
                wptr_q        <= ptr_inc(wptr_q);
            end
            if (pop) rptr_q <= ptr_inc(rptr_q);
            count_q       <= count_d;
            frame_error_q <= ferr_event;
            overrun_q     <= drop;
        end
    end

    assign rx_if.rx_data  = mem_q[rptr_q];
    assign rx_if.rx_valid = (count_q != '0);
    assign fifo_count     = count_q;
    assign frame_error    = frame_error_q;
    assign overrun        = overrun_q;

endmodule
